serial_add_sub: RTL

- Multi-cycle, bit-serial adder/subtractor built around one `full_adder` instance, with a registered carry flip-flop between bit steps.
- Processes one operand bit per clock, LSB first, and presents a registered WIDTH-bit result with carry and signed-overflow flags.
- Sits between the operand/control front end and the ALU result path: a small-area alternative to a WIDTH-wide ripple chain of `full_adder` cells.
- Uses a start/busy/done handshake.

---
 rtl/serial_add_sub_if.sv | 25 ++
 rtl/serial_add_sub.sv | 131 +++++++++++++
 2 files changed

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The front end drives operands through master; the arithmetic core answers through slave.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop, one operand bit per clock,
// LSB first, with a start/busy/done handshake and registered sum/carry/overflow.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_add_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy;
    logic             done;
    logic             faSum;
    logic             faCarry;

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (faSum),
        .c_o (faCarry)
    );

    // Subtraction is a + ~b + 1: the inversion happens at load, the +1 rides in on the carry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = {faSum, r_q[WIDTH-1:1]};
                carry_d = faCarry;
                cnt_d   = cnt_q + CNT_W'(1);
                // On the MSB step carry_q is the carry into the MSB, so overflow needs no extra flop.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {faSum, r_q[WIDTH-1:1]};
                    cout_d  = faCarry;
                    ovf_d   = carry_q ^ faCarry;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
